// File: rtl/systolic_pkg.sv
// ============================================================================
// Module      : systolic_pkg
// Description : Shared sizing defaults and element type for the systolic
//               scheduler, PE array and output collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

  localparam int C_MATRIX_SIZE = 2;
  localparam int C_DATA_SIZE   = 32;
  localparam int C_FIFO_DEPTH  = 4;

  typedef logic [C_DATA_SIZE-1:0] psum_t;

  // A depth-1 FIFO still needs a one-bit pointer to index its storage.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_output_collector_if.sv
// ============================================================================
// Module      : systolic_output_collector_if
// Description : Skewed bottom-row results in, de-skewed rows out on
//               valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_output_collector_if
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = C_MATRIX_SIZE,
  parameter int DATA_SIZE   = C_DATA_SIZE
);

  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] in_psum;
  logic [MATRIX_SIZE-1:0]                in_valid;
  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0] out_row;
  logic                                  out_valid;
  logic                                  out_ready;

  modport master (
    output in_psum,
    output in_valid,
    output out_ready,
    input  out_row,
    input  out_valid
  );

  modport slave (
    input  in_psum,
    input  in_valid,
    input  out_ready,
    output out_row,
    output out_valid
  );

endinterface

`default_nettype wire

// File: rtl/systolic_output_collector_col_fifo.sv
// ============================================================================
// Module      : systolic_output_collector_col_fifo
// Description : Per-column result FIFO; push while full is accepted only
//               when the same cycle pops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_output_collector_col_fifo
  import systolic_pkg::*;
#(
  parameter int FIFO_DEPTH = C_FIFO_DEPTH,
  parameter int DATA_SIZE  = C_DATA_SIZE
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 i_clear,
  input  wire logic                 i_push,
  input  wire logic                 i_pop,
  input  wire logic [DATA_SIZE-1:0] i_data,
  output logic      [DATA_SIZE-1:0] o_head,
  output logic                      o_full,
  output logic                      o_empty
);

  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_SIZE-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an empty FIFO presents zero at its head.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

`default_nettype wire

// File: rtl/systolic_output_collector.sv
// ============================================================================
// Module      : systolic_output_collector
// Description : De-skews bottom-row systolic results into whole rows, hands
//               them downstream and flags job completion / dropped data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_output_collector
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = C_MATRIX_SIZE,
  parameter int DATA_SIZE   = C_DATA_SIZE,
  parameter int FIFO_DEPTH  = C_FIFO_DEPTH
) (
  input  wire logic                     clk,
  input  wire logic                     reset,
  input  wire logic                     start,
  systolic_output_collector_if.slave    bus,
  output logic                          done,
  output logic                          overflow
);

  localparam int RW = $clog2(MATRIX_SIZE + 1);

  logic [MATRIX_SIZE-1:0] w_push;
  logic [MATRIX_SIZE-1:0] w_full;
  logic [MATRIX_SIZE-1:0] w_empty;
  logic [MATRIX_SIZE-1:0] w_drop;
  logic                   w_pop;
  logic                   w_row_ready;

  logic [RW-1:0]          r_row_cnt;
  logic                   r_done;
  logic                   r_overflow;

  generate
    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_col
      assign w_push[c] = bus.in_valid[c] & ~r_done & ~start;
      // A push is lost when the job is finished or the column is full and
      // not being drained this cycle.
      assign w_drop[c] = bus.in_valid[c] & ~start & (r_done | (w_full[c] & ~w_pop));

      systolic_output_collector_col_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_SIZE  (DATA_SIZE)
      ) u_col_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_clear (start),
        .i_push  (w_push[c]),
        .i_pop   (w_pop),
        .i_data  (bus.in_psum[c]),
        .o_head  (bus.out_row[c]),
        .o_full  (w_full[c]),
        .o_empty (w_empty[c])
      );
    end
  endgenerate

  assign w_row_ready   = ~(|w_empty) & ~r_done;
  assign bus.out_valid = w_row_ready;
  assign w_pop         = w_row_ready & bus.out_ready & ~start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row_cnt  <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (start) begin
      r_row_cnt  <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_row_cnt <= r_row_cnt + RW'(1);
        if (r_row_cnt == RW'(MATRIX_SIZE - 1)) r_done <= 1'b1;
      end
      if (|w_drop) r_overflow <= 1'b1;
    end
  end

  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

`default_nettype wire
